// File: rtl/mac_accumulator_if.sv
// Handshake and result bundle between the multiplier-side producer, the
// accumulate stage and its result consumer.
interface mac_accumulator_if #(
  parameter int WIDTH = 31,
  parameter int CNT_W = 8
);
  logic [WIDTH:0]   prod_i;
  logic [1:0]       op_i;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH:0]   acc_o;
  logic             ovf_o;
  logic             zero_o;
  logic             neg_o;
  logic [CNT_W-1:0] cnt_o;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output prod_i, op_i, in_valid, out_ready,
    input  in_ready, acc_o, ovf_o, zero_o, neg_o, cnt_o, out_valid
  );

  modport slave (
    input  prod_i, op_i, in_valid, out_ready,
    output in_ready, acc_o, ovf_o, zero_o, neg_o, cnt_o, out_valid
  );
endinterface

// File: rtl/mac_accumulator.sv
// Signed load/add/sub/clear accumulator behind the multiplier, one-deep result
// register on a valid/ready handshake. Define MAC_SATURATE_EN to clamp on overflow.
//
// state   | meaning
// S_EMPTY | no result pending, out_valid=0
// S_FULL  | result held on outputs, out_valid=1
module mac_accumulator #(
  parameter int WIDTH = 31,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  mac_accumulator_if.slave  bus
);

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [WIDTH:0]   ACC_MAX = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0]   ACC_MIN = {1'b1, {WIDTH{1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             in_ready;
  logic             accept;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             ovf_add;
  logic             ovf_sub;

  assign in_ready = !rst && (state_q == S_EMPTY || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  assign sum     = acc_q + bus.prod_i;
  assign diff    = acc_q - bus.prod_i;
  assign ovf_add = (acc_q[WIDTH] == bus.prod_i[WIDTH]) && (sum[WIDTH] != acc_q[WIDTH]);
  assign ovf_sub = (acc_q[WIDTH] != bus.prod_i[WIDTH]) && (diff[WIDTH] != acc_q[WIDTH]);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    if (accept) begin
      state_d = S_FULL;
      case (bus.op_i)
        OP_LOAD: begin
          acc_d = bus.prod_i;
          ovf_d = 1'b0;
          cnt_d = '0;
        end
        OP_ADD, OP_SUB: begin
          // Either overflow direction follows the accumulator's sign.
`ifdef MAC_SATURATE_EN
          if ((bus.op_i == OP_ADD) ? ovf_add : ovf_sub)
            acc_d = acc_q[WIDTH] ? ACC_MIN : ACC_MAX;
          else
            acc_d = (bus.op_i == OP_ADD) ? sum : diff;
`else
          acc_d = (bus.op_i == OP_ADD) ? sum : diff;
`endif
          ovf_d = ovf_q | ((bus.op_i == OP_ADD) ? ovf_add : ovf_sub);
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
        OP_CLEAR: begin
          acc_d = '0;
          ovf_d = 1'b0;
          cnt_d = '0;
        end
        default: ;
      endcase
    end else if (state_q == S_FULL && bus.out_ready) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.acc_o     = acc_q;
  assign bus.ovf_o     = ovf_q;
  assign bus.zero_o    = (acc_q == '0);
  assign bus.neg_o     = acc_q[WIDTH];
  assign bus.cnt_o     = cnt_q;
  assign bus.out_valid = (state_q == S_FULL);

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator (WIDTH=7, CNT_W=2): directed cases then random traffic
// against an integer-arithmetic model. Honours MAC_SATURATE_EN like the design.
module tb_mac_accumulator;

  localparam int W = 7;
  localparam int C = 2;
  localparam logic [1:0] LD = 2'b00, AD = 2'b01, SB = 2'b10, CL = 2'b11;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  // reference state
  bit       m_full;
  int       m_acc;
  bit       m_ovf;
  int       m_cnt;

  mac_accumulator_if #(.WIDTH(W), .CNT_W(C)) bus ();
  mac_accumulator #(.WIDTH(W), .CNT_W(C)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // m_acc holds the signed value in -128..127
  task automatic model_op(input logic [1:0] op, input logic [7:0] p);
    int pv, r;
    pv = int'($signed(p));
    case (op)
      LD: begin m_acc = pv; m_ovf = 0; m_cnt = 0; end
      CL: begin m_acc = 0;  m_ovf = 0; m_cnt = 0; end
      default: begin
        r = (op == AD) ? m_acc + pv : m_acc - pv;
        if (r > 127 || r < -128) m_ovf = 1;
`ifdef MAC_SATURATE_EN
        if (r > 127) r = 127;
        else if (r < -128) r = -128;
`else
        if (r > 127) r -= 256;
        else if (r < -128) r += 256;
`endif
        m_acc = r;
        if (m_cnt < 3) m_cnt++;
      end
    endcase
  endtask

  // Called just after a falling edge; returns after the next falling edge.
  task automatic step(input logic r, input logic v, input logic [1:0] op,
                      input logic [7:0] p, input logic ordy, output logic rdy);
    logic exp_rdy;
    logic [7:0] acc8;
    rst = r; bus.in_valid = v; bus.op_i = op; bus.prod_i = p; bus.out_ready = ordy;
    #1;
    exp_rdy = !r && (!m_full || ordy);
    rdy = bus.in_ready;
    chk("in_ready", bus.in_ready, exp_rdy);
    if (r) begin
      m_full = 0; m_acc = 0; m_ovf = 0; m_cnt = 0;
    end else if (v && exp_rdy) begin
      model_op(op, p);
      m_full = 1;
    end else if (m_full && ordy) begin
      m_full = 0;
    end
    @(posedge clk);
    @(negedge clk);
    acc8 = m_acc[7:0];
    chk("out_valid", bus.out_valid, m_full);
    chk("acc_o",     bus.acc_o,     acc8);
    chk("ovf_o",     bus.ovf_o,     m_ovf);
    chk("zero_o",    bus.zero_o,    acc8 == 8'h00);
    chk("neg_o",     bus.neg_o,     acc8[7]);
    chk("cnt_o",     bus.cnt_o,     m_cnt);
  endtask

  initial begin
    logic rd;
    int cseq[5];
    logic hold;
    logic v, o, rr;
    logic [1:0] op;
    logic [7:0] p;
    cseq = '{1, 2, 3, 3, 3};
    m_full = 0; m_acc = 0; m_ovf = 0; m_cnt = 0;

    step(1, 0, LD, 8'h00, 0, rd);
    step(1, 1, AD, 8'h11, 1, rd);
    chk("rst_zero", bus.zero_o, 1'b1);

    // basic load/add
    step(0, 1, LD, 8'h10, 1, rd);
    chk("ld10_acc", bus.acc_o, 8'h10);
    step(0, 1, AD, 8'h20, 1, rd);
    chk("add20_acc", bus.acc_o, 8'h30);
    chk("add20_cnt", bus.cnt_o, 2'd1);
    chk("add20_rdy", rd, 1'b1);

    // positive overflow
    step(0, 1, LD, 8'h70, 1, rd);
    step(0, 1, AD, 8'h20, 1, rd);
`ifdef MAC_SATURATE_EN
    chk("povf_acc", bus.acc_o, 8'h7F);
`else
    chk("povf_acc", bus.acc_o, 8'h90);
    chk("povf_neg", bus.neg_o, 1'b1);
`endif
    chk("povf_ovf", bus.ovf_o, 1'b1);
    step(0, 1, LD, 8'h01, 1, rd);
    chk("ld_clr_ovf", bus.ovf_o, 1'b0);

    // negative overflow then clear
    step(0, 1, LD, 8'h80, 1, rd);
    step(0, 1, SB, 8'h01, 1, rd);
`ifdef MAC_SATURATE_EN
    chk("novf_acc", bus.acc_o, 8'h80);
`else
    chk("novf_acc", bus.acc_o, 8'h7F);
`endif
    chk("novf_ovf", bus.ovf_o, 1'b1);
    step(0, 1, CL, 8'h55, 1, rd);
    chk("clr_acc", bus.acc_o, 8'h00);
    chk("clr_valid", bus.out_valid, 1'b1);
    chk("clr_ovf", bus.ovf_o, 1'b0);

    // backpressure
    step(0, 1, LD, 8'h05, 1, rd);
    step(0, 1, AD, 8'h03, 0, rd);
    chk("bp_rdy", rd, 1'b0);
    chk("bp_hold", bus.acc_o, 8'h05);
    step(0, 1, AD, 8'h03, 0, rd);
    chk("bp_hold2", bus.acc_o, 8'h05);
    step(0, 1, AD, 8'h03, 1, rd);
    chk("bp_rel", bus.acc_o, 8'h08);
    chk("bp_valid", bus.out_valid, 1'b1);

    // drain to EMPTY, acc retained
    step(0, 0, LD, 8'h00, 1, rd);
    chk("drain_valid", bus.out_valid, 1'b0);
    chk("drain_acc", bus.acc_o, 8'h08);

    // counter saturation
    step(0, 1, LD, 8'h01, 1, rd);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, AD, 8'h01, 1, rd);
      chk("cnt_seq", bus.cnt_o, cseq[i]);
    end
    chk("cnt_acc", bus.acc_o, 8'h06);

    // reset while FULL with a pending accept
    step(0, 1, LD, 8'h33, 0, rd);
    step(1, 1, AD, 8'h09, 1, rd);
    chk("rst_rdy", rd, 1'b0);
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_acc", bus.acc_o, 8'h00);
    step(0, 1, AD, 8'h04, 1, rd);
    chk("post_rst_acc", bus.acc_o, 8'h04);

    // random traffic; producer holds its word while stalled
    hold = 0; op = LD; p = 8'h00;
    for (int i = 0; i < 400; i++) begin
      rr = ($urandom_range(0, 49) == 0);
      o  = ($urandom_range(0, 9) < 7);
      if (!hold) begin
        v  = ($urandom_range(0, 9) < 7);
        op = ($urandom_range(0, 9) < 7) ? (($urandom_range(0, 1) == 0) ? AD : SB)
                                        : (($urandom_range(0, 1) == 0) ? LD : CL);
        p  = 8'($urandom);
      end
      step(rr, v, op, p, o, rd);
      hold = v && !rd && !rr;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
